// File: rtl/noc_inject_arbiter.sv
// -----------------------------------------------------------------------------
// NoC injection arbiter.
//
// Shares one router local injection port among NUM_REQUESTERS endpoint
// sources. Arbitration is packet-level wormhole: a round-robin winner keeps
// the port until its tail flit is accepted. The arbiter also tracks the
// router's input-buffer credits and never sends a flit without a credit.
//
// Ports:
//   clk, rst      clock; asynchronous active-high reset
//   req_data      per-requester flit payload (flattened, requester i at slice i)
//   req_dest      per-requester destination (flattened)
//   req_is_tail   per-requester tail marker
//   req_valid     per-requester flit offered (held stable until accepted)
//   req_ready     per-requester accept strobe (valid & ready = accepted)
//   data_out      registered flit payload to the router
//   dest_out      registered destination to the router
//   is_tail_out   registered tail marker to the router
//   send_out      one-cycle pulse per flit sent
//   credit_in     one-cycle pulse, router freed one input-buffer slot
//   busy          high while a multi-flit packet owns the port
// -----------------------------------------------------------------------------
module noc_inject_arbiter #(
    parameter int NUM_REQUESTERS    = 4,
    parameter int DEST_WIDTH        = 4,
    parameter int FLIT_WIDTH        = 256,
    parameter int FLIT_BUFFER_DEPTH = 2
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [NUM_REQUESTERS*FLIT_WIDTH-1:0] req_data,
    input  logic [NUM_REQUESTERS*DEST_WIDTH-1:0] req_dest,
    input  logic [NUM_REQUESTERS-1:0]            req_is_tail,
    input  logic [NUM_REQUESTERS-1:0]            req_valid,
    output logic [NUM_REQUESTERS-1:0]            req_ready,
    output logic [FLIT_WIDTH-1:0]                data_out,
    output logic [DEST_WIDTH-1:0]                dest_out,
    output logic                                 is_tail_out,
    output logic                                 send_out,
    input  logic                                 credit_in,
    output logic                                 busy
);

    localparam int PTR_WIDTH    = (NUM_REQUESTERS > 1) ? $clog2(NUM_REQUESTERS) : 1;
    localparam int CREDIT_WIDTH = $clog2(FLIT_BUFFER_DEPTH + 1);
    localparam logic [CREDIT_WIDTH-1:0] CREDIT_MAX = CREDIT_WIDTH'(FLIT_BUFFER_DEPTH);

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [PTR_WIDTH-1:0]    rr_ptr_q, rr_ptr_d;
    logic [PTR_WIDTH-1:0]    owner_q, owner_d;
    logic [CREDIT_WIDTH-1:0] credits_q, credits_d;
    logic [FLIT_WIDTH-1:0]   data_q;
    logic [DEST_WIDTH-1:0]   dest_q;
    logic                    tail_q;
    logic                    send_q;

    logic [PTR_WIDTH-1:0]    cand;
    logic [PTR_WIDTH-1:0]    winner;
    logic                    winner_found;
    logic [PTR_WIDTH-1:0]    sel;
    logic [PTR_WIDTH-1:0]    sel_next;
    logic                    sel_active;
    logic                    sel_valid;
    logic                    sel_tail;
    logic [FLIT_WIDTH-1:0]   sel_data;
    logic [DEST_WIDTH-1:0]   sel_dest;
    logic                    credit_avail;
    logic                    accept;

    // Round-robin search: first valid requester starting at rr_ptr_q.
    always_comb begin
        winner_found = 1'b0;
        winner       = '0;
        cand         = '0;
        for (int i = 0; i < NUM_REQUESTERS; i++) begin
            cand = PTR_WIDTH'((int'(rr_ptr_q) + i) % NUM_REQUESTERS);
            if (!winner_found && req_valid[cand]) begin
                winner_found = 1'b1;
                winner       = cand;
            end
        end
    end

    // Selected requester: the locked owner mid-packet, otherwise the
    // round-robin winner. Ready depends only on the registered credit count,
    // so there is no combinational path from credit_in to req_ready.
    always_comb begin
        sel          = (state_q == LOCKED) ? owner_q : winner;
        sel_active   = (state_q == LOCKED) || winner_found;
        credit_avail = (credits_q != '0);
        sel_valid    = 1'b0;
        sel_tail     = 1'b0;
        sel_data     = '0;
        sel_dest     = '0;
        req_ready    = '0;
        for (int i = 0; i < NUM_REQUESTERS; i++) begin
            if (sel == PTR_WIDTH'(i)) begin
                sel_valid    = req_valid[i];
                sel_tail     = req_is_tail[i];
                sel_data     = req_data[i*FLIT_WIDTH +: FLIT_WIDTH];
                sel_dest     = req_dest[i*DEST_WIDTH +: DEST_WIDTH];
                req_ready[i] = sel_active & credit_avail;
            end
        end
        accept   = sel_active & credit_avail & sel_valid;
        sel_next = PTR_WIDTH'((int'(sel) + 1) % NUM_REQUESTERS);
    end

    // Packet-level FSM: a non-tail accept locks the port to the sender, a
    // tail accept releases it and moves the round-robin pointer past it.
    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        rr_ptr_d = rr_ptr_q;
        if (accept) begin
            if (sel_tail) begin
                state_d  = IDLE;
                rr_ptr_d = sel_next;
            end else begin
                state_d = LOCKED;
                owner_d = sel;
            end
        end
    end

    // Credit counter: a flit sent consumes a slot, credit_in returns one.
    // A surplus credit at the maximum saturates instead of wrapping.
    always_comb begin
        credits_d = credits_q;
        if (accept && !credit_in) begin
            credits_d = credits_q - CREDIT_WIDTH'(1);
        end else if (credit_in && !accept && (credits_q != CREDIT_MAX)) begin
            credits_d = credits_q + CREDIT_WIDTH'(1);
        end
    end

    // State, pointer and credit registers plus the registered output stage.
    // Output fields only load on accept so they hold between flits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            rr_ptr_q  <= '0;
            owner_q   <= '0;
            credits_q <= CREDIT_MAX;
            data_q    <= '0;
            dest_q    <= '0;
            tail_q    <= 1'b0;
            send_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            owner_q   <= owner_d;
            credits_q <= credits_d;
            send_q    <= accept;
            if (accept) begin
                data_q <= sel_data;
                dest_q <= sel_dest;
                tail_q <= sel_tail;
            end
        end
    end

    assign data_out    = data_q;
    assign dest_out    = dest_q;
    assign is_tail_out = tail_q;
    assign send_out    = send_q;
    assign busy        = (state_q == LOCKED);

    // A credit returned while the counter is already full means the router
    // and this arbiter disagree about buffer occupancy.
    credit_overflow_a : assert property (@(posedge clk) disable iff (rst)
        !(credit_in && !accept && (credits_q == CREDIT_MAX)));

endmodule

// File: tb/tb_noc_inject_arbiter.sv
// -----------------------------------------------------------------------------
// Testbench for noc_inject_arbiter.
//
// A behavioural model (owner index or -1, round-robin pointer, credit count)
// predicts req_ready and the registered router-side outputs each cycle; one
// compare process checks the DUT against it on every falling edge. Directed
// scenarios add literal expectations on the sequence of flits sent and on
// the model's own state.
// -----------------------------------------------------------------------------
module tb_noc_inject_arbiter;

    localparam int N     = 4;
    localparam int DW    = 4;
    localparam int FW    = 256;
    localparam int DEPTH = 2;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N*FW-1:0] req_data    = '0;
    logic [N*DW-1:0] req_dest    = '0;
    logic [N-1:0]    req_is_tail = '0;
    logic [N-1:0]    req_valid   = '0;
    logic [N-1:0]    req_ready;
    logic [FW-1:0]   data_out;
    logic [DW-1:0]   dest_out;
    logic            is_tail_out;
    logic            send_out;
    logic            credit_in = 1'b0;
    logic            busy;

    int nCompared   = 0;
    int nMismatched = 0;
    int cyc         = 0;

    // Router-side credit behaviour: 0 = manual pulses only, 1 = echo each send
    // two cycles later.
    int   credMode    = 0;
    logic manualPulse = 1'b0;
    logic d1 = 1'b0;
    logic d2 = 1'b0;

    // Model state
    int            mOwner = -1;
    int            mRr    = 0;
    int            mCred  = DEPTH;
    logic          mSend  = 1'b0;
    logic [FW-1:0] mData  = '0;
    logic [DW-1:0] mDest  = '0;
    logic          mTail  = 1'b0;
    logic          mBusy  = 1'b0;

    // Log of flits seen on the router side
    logic [DW-1:0] sentDest[$];
    logic          sentTail[$];
    logic [15:0]   sentData[$];
    int            sentCyc[$];

    noc_inject_arbiter #(
        .NUM_REQUESTERS   (N),
        .DEST_WIDTH       (DW),
        .FLIT_WIDTH       (FW),
        .FLIT_BUFFER_DEPTH(DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_data   (req_data),
        .req_dest   (req_dest),
        .req_is_tail(req_is_tail),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .data_out   (data_out),
        .dest_out   (dest_out),
        .is_tail_out(is_tail_out),
        .send_out   (send_out),
        .credit_in  (credit_in),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [255:0] actual,
                               input logic [255:0] expected);
        nCompared++;
        if (actual !== expected) begin
            nMismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input int r, input logic [FW-1:0] data,
                                 input logic [DW-1:0] dest, input logic tail,
                                 input logic valid);
        req_data[r*FW +: FW] = data;
        req_dest[r*DW +: DW] = dest;
        req_is_tail[r]       = tail;
        req_valid[r]         = valid;
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clearLog();
        sentDest.delete();
        sentTail.delete();
        sentData.delete();
        sentCyc.delete();
    endtask

    // Offers an nFlits packet from requester r, holding each flit until it is
    // accepted. Called at posedge+1; returns at posedge+1 after the tail.
    task automatic sendPacket(input int r, input int nFlits,
                              input logic [DW-1:0] dest, input int base);
        logic acc;
        int   waited;
        for (int f = 0; f < nFlits; f++) begin
            applyStimulus(r, FW'(base + f), dest, (f == nFlits - 1), 1'b1);
            acc    = 1'b0;
            waited = 0;
            while (!acc && waited < 100) begin
                @(negedge clk);
                acc = req_ready[r];
                @(posedge clk);
                #1;
                waited++;
            end
            if (!acc) begin
                nCompared++;
                nMismatched++;
                $display("[TB] FAIL sendPacket timeout: requester %0d flit %0d got no accept, expected accept within 100 cycles",
                         r, f);
            end
        end
        applyStimulus(r, '0, '0, 1'b0, 1'b0);
    endtask

    // First valid requester from the round-robin pointer, or the owner when a
    // packet is in flight; -1 when nobody is selected.
    function automatic int modelSel();
        if (mOwner >= 0) return mOwner;
        for (int i = 0; i < N; i++) begin
            if (req_valid[(mRr + i) % N]) return (mRr + i) % N;
        end
        return -1;
    endfunction

    // Router-side credit source, updated mid-cycle after the stimulus slot.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (credMode == 1) credit_in = d2;
            else               credit_in = manualPulse;
            manualPulse = 1'b0;
            d2 = d1;
            d1 = send_out;
        end
    end

    // Log every flit the DUT sends.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && send_out) begin
                sentDest.push_back(dest_out);
                sentTail.push_back(is_tail_out);
                sentData.push_back(data_out[15:0]);
                sentCyc.push_back(cyc);
            end
        end
    end

    // Compare process: check outputs of the last edge, then predict the next.
    initial begin
        int            s;
        logic [N-1:0]  expReady;
        logic          acc;
        forever begin
            @(negedge clk);
            if (rst) begin
                mOwner = -1;
                mRr    = 0;
                mCred  = DEPTH;
                mSend  = 1'b0;
                mData  = '0;
                mDest  = '0;
                mTail  = 1'b0;
                mBusy  = 1'b0;
            end
            checkOutput("send_out",    256'(send_out),    256'(mSend));
            checkOutput("data_out",    data_out,          mData);
            checkOutput("dest_out",    256'(dest_out),    256'(mDest));
            checkOutput("is_tail_out", 256'(is_tail_out), 256'(mTail));
            checkOutput("busy",        256'(busy),        256'(mBusy));
            s        = modelSel();
            expReady = '0;
            acc      = 1'b0;
            if (s >= 0 && mCred > 0) begin
                expReady[s] = 1'b1;
                acc         = req_valid[s];
            end
            checkOutput("req_ready", 256'(req_ready), 256'(expReady));
            if (!rst) begin
                if (acc) begin
                    mSend = 1'b1;
                    mData = req_data[s*FW +: FW];
                    mDest = req_dest[s*DW +: DW];
                    mTail = req_is_tail[s];
                    if (mTail) begin
                        mOwner = -1;
                        mRr    = (s + 1) % N;
                    end else begin
                        mOwner = s;
                    end
                end else begin
                    mSend = 1'b0;
                end
                mCred = mCred - (acc ? 1 : 0) + (credit_in ? 1 : 0);
                if (mCred > DEPTH) mCred = DEPTH;
                mBusy = (mOwner >= 0);
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // Reset then idle
        waitCycles(3);
        rst = 1'b0;
        waitCycles(3);
        checkOutput("idle req_ready", 256'(req_ready), 256'(0));
        checkOutput("idle send_out",  256'(send_out),  256'(0));
        checkOutput("idle busy",      256'(busy),      256'(0));
        checkOutput("model credits after reset", 256'(mCred), 256'(2));

        // Requester 1, 3-flit packet to dest 5, credits echoed
        credMode = 1;
        clearLog();
        sendPacket(1, 3, 4'd5, 'h100);
        waitCycles(4);
        credMode = 0;
        checkOutput("t2 flit count", 256'(sentDest.size()), 256'(3));
        if (sentDest.size() == 3) begin
            checkOutput("t2 dest0", 256'(sentDest[0]), 256'(5));
            checkOutput("t2 dest2", 256'(sentDest[2]), 256'(5));
            checkOutput("t2 tail1", 256'(sentTail[1]), 256'(0));
            checkOutput("t2 tail2", 256'(sentTail[2]), 256'(1));
            checkOutput("t2 data2", 256'(sentData[2]), 256'('h102));
        end
        checkOutput("model rr after t2", 256'(mRr), 256'(2));

        // Requester 3 single flit moves rr to 0, then 0 and 2 compete
        credMode = 1;
        clearLog();
        sendPacket(3, 1, 4'd1, 'h300);
        fork
            sendPacket(0, 2, 4'd3, 'h310);
            sendPacket(2, 2, 4'd7, 'h320);
        join
        waitCycles(4);
        credMode = 0;
        checkOutput("t3 flit count", 256'(sentDest.size()), 256'(5));
        if (sentDest.size() == 5) begin
            checkOutput("t3 order1", 256'(sentDest[1]), 256'(3));
            checkOutput("t3 order2", 256'(sentDest[2]), 256'(3));
            checkOutput("t3 order3", 256'(sentDest[3]), 256'(7));
            checkOutput("t3 order4", 256'(sentDest[4]), 256'(7));
        end
        checkOutput("model rr after t3", 256'(mRr), 256'(3));

        // Credit starvation: requester 0, 4 flits, no credits returned
        clearLog();
        fork
            sendPacket(0, 4, 4'd9, 'h400);
            begin
                waitCycles(8);
                checkOutput("t4 sends before credit", 256'(sentDest.size()), 256'(2));
                checkOutput("t4 stalled ready",       256'(req_ready),       256'(0));
                manualPulse = 1'b1;
                waitCycles(1);
                checkOutput("t4 ready after credit",  256'(req_ready),       256'(1));
                checkOutput("t4 no send yet",         256'(sentDest.size()), 256'(2));
                waitCycles(1);
                checkOutput("t4 send after credit",   256'(send_out),        256'(1));
                waitCycles(4);
                checkOutput("t4 one more send",       256'(sentDest.size()), 256'(3));
                manualPulse = 1'b1;
                waitCycles(5);
            end
        join
        waitCycles(1);
        checkOutput("t4 total sends", 256'(sentDest.size()), 256'(4));
        if (sentDest.size() == 4) begin
            checkOutput("t4 tail", 256'(sentTail[3]), 256'(1));
            checkOutput("t4 dest", 256'(sentDest[3]), 256'(9));
        end
        manualPulse = 1'b1;
        waitCycles(1);
        manualPulse = 1'b1;
        waitCycles(2);
        checkOutput("model credits after t4", 256'(mCred), 256'(2));

        // Sustained stream with accept and credit_in together at credits=1
        clearLog();
        applyStimulus(1, FW'('h500), 4'd6, 1'b0, 1'b1);
        waitCycles(1);
        applyStimulus(1, FW'('h501), 4'd6, 1'b0, 1'b1);
        manualPulse = 1'b1;
        waitCycles(1);
        applyStimulus(1, FW'('h502), 4'd6, 1'b0, 1'b1);
        manualPulse = 1'b1;
        waitCycles(1);
        applyStimulus(1, FW'('h503), 4'd6, 1'b1, 1'b1);
        manualPulse = 1'b1;
        waitCycles(1);
        applyStimulus(1, '0, '0, 1'b0, 1'b0);
        manualPulse = 1'b1;
        waitCycles(3);
        checkOutput("t5 flit count", 256'(sentDest.size()), 256'(4));
        if (sentDest.size() == 4) begin
            checkOutput("t5 back-to-back", 256'(sentCyc[3] - sentCyc[0]), 256'(3));
            checkOutput("t5 last data",    256'(sentData[3]),             256'('h503));
        end
        checkOutput("model credits after t5", 256'(mCred), 256'(2));

        // Reset mid-packet after flit 2 of 4 with credits exhausted
        applyStimulus(0, FW'('h600), 4'd2, 1'b0, 1'b1);
        waitCycles(1);
        applyStimulus(0, FW'('h601), 4'd2, 1'b0, 1'b1);
        waitCycles(1);
        applyStimulus(0, FW'('h602), 4'd2, 1'b0, 1'b1);
        checkOutput("t6 busy before reset", 256'(busy),      256'(1));
        checkOutput("t6 ready at 0 credits", 256'(req_ready), 256'(0));
        rst = 1'b1;
        #1;
        checkOutput("t6 reset send_out",  256'(send_out),  256'(0));
        checkOutput("t6 reset busy",      256'(busy),      256'(0));
        checkOutput("t6 reset req_ready", 256'(req_ready), 256'(1));
        waitCycles(2);
        applyStimulus(0, '0, '0, 1'b0, 1'b0);
        rst = 1'b0;
        clearLog();
        waitCycles(1);
        sendPacket(3, 1, 4'hC, 'h700);
        sendPacket(3, 1, 4'hC, 'h701);
        waitCycles(3);
        checkOutput("t6 flit count", 256'(sentDest.size()), 256'(2));
        if (sentDest.size() == 2) begin
            checkOutput("t6 dest",  256'(sentDest[0]), 256'('hC));
            checkOutput("t6 tail",  256'(sentTail[0]), 256'(1));
            checkOutput("t6 data1", 256'(sentData[1]), 256'('h701));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
